i2s_receiver: RTL and testbench

- Slave-mode I2S serial audio receiver, for an audio ADC or microphone codec. It is the capture-side counterpart of the speaker output path.
- Takes the external bit clock, word select and serial data, and synchronises all three into the system clock domain.
- Deserialises MSB-first two's-complement samples into parallel left/right words.
- Presents one stereo pair per frame with a single-cycle valid strobe, and flags malformed slots.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_in_sync.sv | 46 ++++
 rtl/i2s_receiver.sv | 189 ++++++++++++++++++
 tb/tb_i2s_receiver.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the slave-mode I2S capture path: FSM encoding,
// default geometry and word-select channel encoding.
package i2s_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } i2s_state_e;

  localparam int DEF_SAMPLE_WIDTH  = 16;
  localparam int DEF_MAX_SLOT_BITS = 64;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_in_sync.sv
// Synchronises bck/ws/data into the clk domain through equal-length chains
// (keeping them mutually aligned) and detects bit-clock rising edges.
module i2s_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic audio_bck,
  input  logic audio_ws,
  input  logic audio_data,
  output logic ws_sync,
  output logic data_sync,
  output logic bck_rise
);

  logic [SYNC_STAGES-1:0] bck_q, bck_d;
  logic [SYNC_STAGES-1:0] ws_q, ws_d;
  logic [SYNC_STAGES-1:0] data_q, data_d;
  logic                   bck_prev_q, bck_prev_d;

  always_comb begin
    bck_d      = {bck_q[SYNC_STAGES-2:0], audio_bck};
    ws_d       = {ws_q[SYNC_STAGES-2:0], audio_ws};
    data_d     = {data_q[SYNC_STAGES-2:0], audio_data};
    bck_prev_d = bck_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bck_q      <= '0;
      ws_q       <= '0;
      data_q     <= '0;
      bck_prev_q <= 1'b0;
    end else begin
      bck_q      <= bck_d;
      ws_q       <= ws_d;
      data_q     <= data_d;
      bck_prev_q <= bck_prev_d;
    end
  end

  assign ws_sync   = ws_q[SYNC_STAGES-1];
  assign data_sync = data_q[SYNC_STAGES-1];
  assign bck_rise  = bck_q[SYNC_STAGES-1] & ~bck_prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// Slave I2S receiver: deserialises MSB-first left/right slots into a stereo pair
// with a one-clk strobe. Optional peak meter enabled by defining PEAK_METER_EN.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
  parameter int SYNC_STAGES   = 2,
  parameter int MAX_SLOT_BITS = DEF_MAX_SLOT_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    audio_bck,
  input  logic                    audio_ws,
  input  logic                    audio_data,
`ifdef PEAK_METER_EN
  input  logic                    peak_clr,
  output logic [SAMPLE_WIDTH-1:0] peak_level,
`endif
  output logic [SAMPLE_WIDTH-1:0] audio_left,
  output logic [SAMPLE_WIDTH-1:0] audio_right,
  output logic                    sample_valid,
  output logic                    frame_err
);

  localparam int CW = $clog2(MAX_SLOT_BITS + 1);
  localparam int IW = $clog2(SAMPLE_WIDTH);

  logic ws_s, data_s, bck_rise;

  i2s_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .audio_bck (audio_bck),
    .audio_ws  (audio_ws),
    .audio_data(audio_data),
    .ws_sync   (ws_s),
    .data_sync (data_s),
    .bck_rise  (bck_rise)
  );

  i2s_state_e              state_q, state_d;
  logic                    ws_last_q, ws_last_d;
  logic                    ws_seen_q, ws_seen_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] stage_q, stage_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic [SAMPLE_WIDTH-1:0] word;
  logic [IW-1:0]           bit_idx;
  logic [CW-1:0]           cnt_inc;
  logic                    ws_change;
  logic                    short_slot;

  always_comb begin
    state_d   = state_q;
    ws_last_d = ws_last_q;
    ws_seen_d = ws_seen_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    stage_d   = stage_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    // ws_seen blocks a false slot edge against the reset value of ws_last.
    ws_change  = ws_seen_q && (ws_s != ws_last_q);
    short_slot = cnt_q < CW'(SAMPLE_WIDTH - 1);
    cnt_inc    = (cnt_q == CW'(MAX_SLOT_BITS)) ? cnt_q : cnt_q + CW'(1);
    bit_idx    = IW'(SAMPLE_WIDTH - 1) - cnt_q[IW-1:0];
    word       = shift_q;
    if (cnt_q < CW'(SAMPLE_WIDTH)) begin
      word[bit_idx] = data_s;
    end

    if (bck_rise) begin
      ws_seen_d = 1'b1;
      ws_last_d = ws_s;
      case (state_q)
        HUNT: begin
          if (ws_change) begin
            state_d = RECV;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        RECV: begin
          if (ws_change) begin
            // The bit on a ws-change rise is the closing slot's last bit.
            cnt_d   = '0;
            shift_d = '0;
            err_d   = short_slot;
            if (ws_last_q == WS_LEFT) begin
              stage_d = word;
            end else begin
              left_d  = stage_q;
              right_d = word;
              valid_d = 1'b1;
            end
          end else if (cnt_inc == CW'(MAX_SLOT_BITS)) begin
            err_d   = 1'b1;
            state_d = HUNT;
            stage_d = '0;
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            cnt_d   = cnt_inc;
            shift_d = word;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      ws_last_q <= 1'b0;
      ws_seen_q <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      stage_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ws_last_q <= ws_last_d;
      ws_seen_q <= ws_seen_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      stage_q   <= stage_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign audio_left   = left_q;
  assign audio_right  = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

`ifdef PEAK_METER_EN
  logic [SAMPLE_WIDTH-1:0] peak_q, peak_d;
  logic [SAMPLE_WIDTH-1:0] abs_l, abs_r;

  // Magnitude with the most negative code clamped to the largest positive one.
  function automatic logic [SAMPLE_WIDTH-1:0] abs_sat(input logic [SAMPLE_WIDTH-1:0] v);
    if (!v[SAMPLE_WIDTH-1]) begin
      return v;
    end else if (v == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}) begin
      return {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end else begin
      return -v;
    end
  endfunction

  always_comb begin
    abs_l  = abs_sat(left_q);
    abs_r  = abs_sat(right_q);
    peak_d = peak_clr ? '0 : peak_q;
    if (valid_q) begin
      if (abs_l > peak_d) peak_d = abs_l;
      if (abs_r > peak_d) peak_d = abs_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: directed frame table, corner sequences and random
// frames scored against a slot-level reference model of the I2S stream.
module tb_i2s_receiver;
  import i2s_pkg::*;

  localparam int SW   = 16;
  localparam int MAXB = 64;
  localparam int EW   = 2 * SW + 2;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          audio_bck  = 1'b0;
  logic          audio_ws   = 1'b1;
  logic          audio_data = 1'b0;
  logic [SW-1:0] audio_left;
  logic [SW-1:0] audio_right;
  logic          sample_valid;
  logic          frame_err;
`ifdef PEAK_METER_EN
  logic          peak_clr = 1'b0;
  logic [SW-1:0] peak_level;
`endif

  i2s_receiver #(
    .SAMPLE_WIDTH (SW),
    .SYNC_STAGES  (2),
    .MAX_SLOT_BITS(MAXB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .audio_bck   (audio_bck),
    .audio_ws    (audio_ws),
    .audio_data  (audio_data),
`ifdef PEAK_METER_EN
    .peak_clr    (peak_clr),
    .peak_level  (peak_level),
`endif
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .sample_valid(sample_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  // Expected event record: {valid, err, left, right}; left/right are zero for
  // error-only events.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp, mon_act;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (slot level) ----------------
  bit            m_seen;
  bit            m_ws_last;
  bit            m_hunt;
  bit            m_bits[$];
  logic [SW-1:0] m_stage;
  logic [SW-1:0] m_left, m_right;

  function automatic void model_reset();
    m_seen  = 1'b0;
    m_ws_last = 1'b0;
    m_hunt  = 1'b1;
    m_bits.delete();
    m_stage = '0;
    m_left  = '0;
    m_right = '0;
  endfunction

  function automatic void model_rise(input bit ws, input bit d);
    bit            chg;
    logic [SW-1:0] w;
    chg = m_seen && (ws != m_ws_last);
    if (m_hunt) begin
      if (chg) begin
        m_hunt = 1'b0;
        m_bits.delete();
      end
    end else begin
      m_bits.push_back(d);
      if (chg) begin
        w = '0;
        for (int i = 0; i < SW && i < m_bits.size(); i++) w[SW-1-i] = m_bits[i];
        if (m_ws_last == WS_LEFT) begin
          m_stage = w;
          if (m_bits.size() < SW) exp_q.push_back({1'b0, 1'b1, {SW{1'b0}}, {SW{1'b0}}});
        end else begin
          exp_q.push_back({1'b1, (m_bits.size() < SW) ? 1'b1 : 1'b0, m_stage, w});
          m_left  = m_stage;
          m_right = w;
        end
        m_bits.delete();
      end else if (m_bits.size() >= MAXB) begin
        exp_q.push_back({1'b0, 1'b1, {SW{1'b0}}, {SW{1'b0}}});
        m_hunt  = 1'b1;
        m_stage = '0;
        m_bits.delete();
      end
    end
    m_seen    = 1'b1;
    m_ws_last = ws;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && (sample_valid || frame_err)) begin
      if (sample_valid) valid_cnt++;
      if (frame_err) err_cnt++;
      mon_act = {sample_valid, frame_err,
                 sample_valid ? audio_left : {SW{1'b0}},
                 sample_valid ? audio_right : {SW{1'b0}}};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual=%h expected=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL event actual=%h expected=%h", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // ws/data change while bck is low; data is sampled on the bck rise.
  task automatic tx(input logic ws, input logic d);
    audio_ws   = ws;
    audio_data = d;
    #50;
    audio_bck = 1'b1;
    model_rise(ws, d);
    #50;
    audio_bck = 1'b0;
  endtask

  // Each bit goes out with the ws of the following bit, so ws leads the MSB by one bck.
  logic pend_d;
  bit   have_pend = 1'b0;

  task automatic push_bit(input logic ws, input logic d);
    if (have_pend) tx(ws, pend_d);
    pend_d    = d;
    have_pend = 1'b1;
  endtask

  task automatic flush(input logic next_ws);
    if (have_pend) tx(next_ws, pend_d);
    have_pend = 1'b0;
  endtask

  task automatic send_slot(input logic ws, input logic [31:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) push_bit(ws, word[nbits-1-i]);
  endtask

  task automatic send_frame(input logic [31:0] wl, input int nl, input logic [31:0] wr, input int nr);
    send_slot(WS_LEFT, wl, nl);
    send_slot(WS_RIGHT, wr, nr);
    flush(WS_LEFT);
    #20;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_left", 32'(audio_left), 32'h0);
    check("reset_right", 32'(audio_right), 32'h0);
    check("reset_valid", 32'(sample_valid), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    #29;
    model_reset();
    exp_q.delete();
    have_pend = 1'b0;
    rst = 1'b0;
    #20;
  endtask

  typedef struct {
    int            nl;
    logic [31:0]   wl;
    int            nr;
    logic [31:0]   wr;
    logic [SW-1:0] el;
    logic [SW-1:0] er;
    int            eerr;
  } row_t;

  row_t tbl[6];
  int   v0, e0;

  initial begin
    tbl[0] = '{16, 32'h8001,     16, 32'h7FFE,     16'h8001, 16'h7FFE, 0};
    tbl[1] = '{16, 32'h8001,     16, 32'h7FFE,     16'h8001, 16'h7FFE, 0};
    tbl[2] = '{32, 32'h1234ABCD, 32, 32'hFFFF0000, 16'h1234, 16'hFFFF, 0};
    tbl[3] = '{16, 32'h5A5A,     12, 32'hABC,      16'h5A5A, 16'hABC0, 1};
    tbl[4] = '{24, 32'h00FFEE,   16, 32'h0001,     16'h00FF, 16'h0001, 0};
    tbl[5] = '{8,  32'hC3,       16, 32'h1111,     16'hC300, 16'h1111, 1};

    model_reset();
    #3;
    do_reset();

    // Idle with ws constant: nothing may be produced.
    for (int i = 0; i < 20; i++) push_bit(WS_RIGHT, 1'($urandom_range(0, 1)));
    #20;
    check("idle_valid_cnt", 32'(valid_cnt), 32'h0);
    check("idle_err_cnt", 32'(err_cnt), 32'h0);
    check("idle_state_hunt", 32'(dut.state_q), 32'(HUNT));
    check("idle_left", 32'(audio_left), 32'h0);

    for (int r = 0; r < 6; r++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(tbl[r].wl, tbl[r].nl, tbl[r].wr, tbl[r].nr);
      check($sformatf("row%0d_left", r), 32'(audio_left), 32'(tbl[r].el));
      check($sformatf("row%0d_right", r), 32'(audio_right), 32'(tbl[r].er));
      check($sformatf("row%0d_valid", r), 32'(valid_cnt - v0), 32'h1);
      check($sformatf("row%0d_err", r), 32'(err_cnt - e0), 32'(tbl[r].eerr));
    end

    // Stuck ws in a left slot: error at bit 64, staged left discarded.
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 67; i++) push_bit(WS_LEFT, 1'($urandom_range(0, 1)));
    check("stuck_state_hunt", 32'(dut.state_q), 32'(HUNT));
    check("stuck_err", 32'(err_cnt - e0), 32'h1);
    for (int i = 0; i < 3; i++) push_bit(WS_LEFT, 1'($urandom_range(0, 1)));
    send_slot(WS_RIGHT, 32'h1357, 16);
    flush(WS_LEFT);
    #20;
    check("stuck_left_discarded", 32'(audio_left), 32'h0);
    check("stuck_right", 32'(audio_right), 32'h1357);
    check("stuck_valid", 32'(valid_cnt - v0), 32'h1);
    send_frame(32'h2468, 16, 32'h9BDF, 16);
    check("after_stuck_left", 32'(audio_left), 32'h2468);
    check("after_stuck_right", 32'(audio_right), 32'h9BDF);

    // Reset mid-slot, then resume through HUNT.
    send_slot(WS_LEFT, 32'hFFFF, 10);
    do_reset();
    send_slot(WS_RIGHT, 32'h15, 5);
    send_frame(32'hCAFE, 16, 32'hBEEF, 16);
    check("post_reset_left", 32'(audio_left), 32'hCAFE);
    check("post_reset_right", 32'(audio_right), 32'hBEEF);

    // Random frames of assorted slot lengths.
    for (int f = 0; f < 40; f++) begin
      send_slot(WS_LEFT, $urandom, $urandom_range(8, 32));
      send_slot(WS_RIGHT, $urandom, $urandom_range(8, 32));
    end
    flush(WS_LEFT);
    #200;
    check("hold_left", 32'(audio_left), 32'(m_left));
    check("hold_right", 32'(audio_right), 32'(m_right));

`ifdef PEAK_METER_EN
    do_reset();
    check("peak_reset", 32'(peak_level), 32'h0);
    for (int i = 0; i < 4; i++) push_bit(WS_RIGHT, 1'b0);
    send_frame(32'h0100, 16, 32'hFF00, 16);
    check("peak_pair1", 32'(peak_level), 32'h0100);
    send_frame(32'h8000, 16, 32'h0010, 16);
    check("peak_pair2", 32'(peak_level), 32'h7FFF);
    @(negedge clk);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    @(negedge clk);
    check("peak_clr", 32'(peak_level), 32'h0);
`endif

    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
